// File: rtl/bp_nonsynth_cfg_loader.sv
// Boot-time cfg-bus sequencer: programs each core's cfg registers, then unfreezes all cores.
// Optional BP_CFG_LOADER_READBACK_EN: reads back each cfg write and flags mismatches on error_o.
module bp_nonsynth_cfg_loader #(
  parameter int          num_core_p      = 1,
  parameter int          core_id_width_p = 4,
  parameter int          data_width_p    = 64,
  parameter logic [63:0] boot_pc_p       = 64'h8000_0000,
  parameter int          cce_mode_p      = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  output logic                         cfg_v_o,
  output logic                         cfg_w_o,
  output logic [core_id_width_p+15:0]  cfg_addr_o,
  output logic [data_width_p-1:0]      cfg_data_o,
  input  logic                         cfg_ready_i,
  input  logic                         resp_v_i,
  input  logic [data_width_p-1:0]      resp_data_i,
  output logic                         resp_ready_o,
  output logic                         done_o,
  output logic                         error_o
);
  // state       | meaning
  // S_RESET     | one idle cycle after reset release
  // S_CFG       | write reg_idx of core_idx
  // S_RD        | read back the register just written
  // S_WAIT_RESP | wait for the readback response
  // S_UNFREEZE  | clear FREEZE on core_idx
  // S_DONE      | sequence complete
  localparam int CoreCntW = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam logic [CoreCntW-1:0] LastCore = CoreCntW'(num_core_p - 1);
  localparam logic [15:0] OffFreeze = 16'h0010;
  localparam logic [15:0] OffNpc    = 16'h0020;
  localparam logic [15:0] OffIcache = 16'h0030;
  localparam logic [15:0] OffDcache = 16'h0040;
  localparam logic [15:0] OffCce    = 16'h0050;

  typedef enum logic [2:0] {S_RESET, S_CFG, S_RD, S_WAIT_RESP, S_UNFREEZE, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              reg_idx_q, reg_idx_d;
  logic [CoreCntW-1:0]     core_idx_q, core_idx_d;
  logic                    done_q;
  logic                    advance;
  logic [15:0]             reg_off, off;
  logic [data_width_p-1:0] reg_val;

  always_comb begin
    reg_off = OffFreeze;
    reg_val = data_width_p'(1);
    unique case (reg_idx_q)
      3'd1: begin
        reg_off = OffNpc;
        reg_val = data_width_p'(boot_pc_p);
      end
      3'd2: reg_off = OffIcache;
      3'd3: reg_off = OffDcache;
      3'd4: begin
        reg_off = OffCce;
        reg_val = data_width_p'(cce_mode_p);
      end
      default: ;
    endcase
  end

`ifdef BP_CFG_LOADER_READBACK_EN
  logic error_q, error_d;
`else
  logic unused_resp;
  assign unused_resp = ^{resp_v_i, resp_data_i};
`endif

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    core_idx_d = core_idx_q;
    advance    = 1'b0;
    cfg_v_o    = 1'b0;
    off        = 16'h0000;
    cfg_data_o = '0;
`ifdef BP_CFG_LOADER_READBACK_EN
    cfg_w_o      = 1'b0;
    resp_ready_o = 1'b0;
    error_d      = error_q;
`else
    cfg_w_o      = 1'b1;
    resp_ready_o = 1'b1;
`endif
    unique case (state_q)
      S_RESET: state_d = S_CFG;
      S_CFG: begin
        cfg_v_o    = 1'b1;
        off        = reg_off;
        cfg_data_o = reg_val;
`ifdef BP_CFG_LOADER_READBACK_EN
        cfg_w_o = 1'b1;
        if (cfg_ready_i) state_d = S_RD;
`else
        advance = cfg_ready_i;
`endif
      end
`ifdef BP_CFG_LOADER_READBACK_EN
      S_RD: begin
        cfg_v_o    = 1'b1;
        off        = reg_off;
        cfg_data_o = reg_val;
        if (cfg_ready_i) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        resp_ready_o = 1'b1;
        if (resp_v_i) begin
          advance = 1'b1;
          if (resp_data_i != reg_val) error_d = 1'b1;
        end
      end
`endif
      S_UNFREEZE: begin
        cfg_v_o = 1'b1;
        off     = OffFreeze;
`ifdef BP_CFG_LOADER_READBACK_EN
        cfg_w_o = 1'b1;
`endif
        if (cfg_ready_i) begin
          if (core_idx_q == LastCore) begin
            core_idx_d = '0;
            state_d    = S_DONE;
          end else begin
            core_idx_d = core_idx_q + 1'b1;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_RESET;
    endcase

    // Register index wraps together with the core step; the last core hands over to unfreeze.
    if (advance) begin
      state_d = S_CFG;
      if (reg_idx_q == 3'd4) begin
        reg_idx_d = '0;
        if (core_idx_q == LastCore) begin
          core_idx_d = '0;
          state_d    = S_UNFREEZE;
        end else begin
          core_idx_d = core_idx_q + 1'b1;
        end
      end else begin
        reg_idx_d = reg_idx_q + 3'd1;
      end
    end
  end

  assign cfg_addr_o = {core_id_width_p'(core_idx_q), off};
  assign done_o     = done_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_RESET;
      reg_idx_q  <= '0;
      core_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      core_idx_q <= core_idx_d;
      done_q     <= done_q | (state_q == S_DONE);
    end
  end

`ifdef BP_CFG_LOADER_READBACK_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_q <= 1'b0;
    else            error_q <= error_d;
  end
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_nonsynth_cfg_loader.sv
// Bench for bp_nonsynth_cfg_loader: 1-core and 4-core instances checked against a request-list model.
// Define BP_CFG_LOADER_READBACK_EN for both RTL and bench to exercise the readback build.
module tb_bp_nonsynth_cfg_loader;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam logic [15:0] OFFS [5] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic          rst1_n, rdy1, rv1, rr1, v1, w1, done1, err1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data1, rd1;
  logic          rst4_n, rdy4, rv4, rr4, v4, w4, done4, err4;
  logic [AW-1:0] addr4;
  logic [DW-1:0] data4, rd4;

  int          dly1     = 0;
  logic        corrupt1 = 1'b0;
  logic [15:0] last_rd1 = '0;
  logic [15:0] last_rd4 = '0;
  req_t        got1[$];
  req_t        got4[$];
  req_t        exp_q[$];

  bp_nonsynth_cfg_loader #(.num_core_p(1)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst1_n), .cfg_v_o(v1), .cfg_w_o(w1), .cfg_addr_o(addr1),
    .cfg_data_o(data1), .cfg_ready_i(rdy1), .resp_v_i(rv1), .resp_data_i(rd1),
    .resp_ready_o(rr1), .done_o(done1), .error_o(err1)
  );

  bp_nonsynth_cfg_loader #(.num_core_p(4)) u_dut4 (
    .clk_i(clk), .reset_n_i(rst4_n), .cfg_v_o(v4), .cfg_w_o(w4), .cfg_addr_o(addr4),
    .cfg_data_o(data4), .cfg_ready_i(rdy4), .resp_v_i(rv4), .resp_data_i(rd4),
    .resp_ready_o(rr4), .done_o(done4), .error_o(err4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value each cfg register should hold after boot (cce mode 1 is the default build).
  function automatic logic [DW-1:0] ref_value(input logic [15:0] off);
    return (off == 16'h0020) ? 64'h8000_0000 : 64'd1;
  endfunction

  task automatic build_exp(input int n);
    req_t e;
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < 5; r++) begin
        e.w = 1'b1;
        e.a = {4'(c), OFFS[r]};
        e.d = ref_value(OFFS[r]);
        exp_q.push_back(e);
`ifdef BP_CFG_LOADER_READBACK_EN
        e.w = 1'b0;
        e.d = '0;
        exp_q.push_back(e);
`endif
      end
    end
    for (int c = 0; c < n; c++) begin
      e.w = 1'b1;
      e.a = {4'(c), 16'h0010};
      e.d = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic cmp_list(input int which, input string tag);
    req_t g[$];
    if (which == 1) g = got1;
    else            g = got4;
    chk({tag, "_count"}, 128'(g.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < g.size(); i++)
      chk($sformatf("%s_req%0d", tag, i), 128'(g[i]), 128'(exp_q[i]));
  endtask

  task automatic run_until_done(input int which, input int budget, input bit rand_rdy,
                                input string tag);
    logic d;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        if (which == 1) rdy1 = ($urandom_range(0, 9) < 3);
        else            rdy4 = ($urandom_range(0, 9) < 3);
      end
      d = (which == 1) ? done1 : done4;
      if (d) break;
    end
    d = (which == 1) ? done1 : done4;
    chk(tag, d, 1);
  endtask

  // Request monitors: record handshakes and check requests are held while stalled.
  initial begin : mon1
    logic stall;
    req_t prev, cur;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst1_n) begin
        stall = 1'b0;
      end else begin
        cur.w = w1;
        cur.a = addr1;
        cur.d = w1 ? data1 : '0;
        if (stall) begin
          chk("u1_hold_v", v1, 1);
          chk("u1_hold_req", 128'(cur), 128'(prev));
        end
`ifdef BP_CFG_LOADER_READBACK_EN
        if (v1) chk("u1_rr_while_req", rr1, 0);
`else
        chk("u1_w_const", w1, 1);
        chk("u1_rr_const", rr1, 1);
        chk("u1_err_const", err1, 0);
`endif
        if (v1 && rdy1) begin
          got1.push_back(cur);
          if (!w1) last_rd1 = addr1[15:0];
        end
        stall = v1 && !rdy1;
        prev  = cur;
      end
    end
  end

  initial begin : mon4
    logic stall;
    req_t prev, cur;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst4_n) begin
        stall = 1'b0;
      end else begin
        cur.w = w4;
        cur.a = addr4;
        cur.d = w4 ? data4 : '0;
        if (stall) begin
          chk("u4_hold_v", v4, 1);
          chk("u4_hold_req", 128'(cur), 128'(prev));
        end
`ifndef BP_CFG_LOADER_READBACK_EN
        chk("u4_w_const", w4, 1);
        chk("u4_err_const", err4, 0);
`endif
        if (v4 && rdy4) begin
          got4.push_back(cur);
          if (!w4) last_rd4 = addr4[15:0];
        end
        stall = v4 && !rdy4;
        prev  = cur;
      end
    end
  end

`ifdef BP_CFG_LOADER_READBACK_EN
  assign rv4 = 1'b1;
  assign rd4 = ref_value(last_rd4);

  initial begin : rsp1
    rv1 = 1'b0;
    rd1 = '0;
    forever begin
      @(posedge clk); #1;
      rv1 = 1'b0;
      if (rst1_n && rr1) begin
        for (int k = 0; k < dly1; k++) begin
          chk("u1_wait_no_v", v1, 0);
          chk("u1_wait_rr", rr1, 1);
          @(posedge clk); #1;
        end
        rv1 = 1'b1;
        rd1 = (corrupt1 && last_rd1 == 16'h0020) ? '0 : ref_value(last_rd1);
      end
    end
  end
`else
  assign rv1 = 1'b0;
  assign rd1 = '0;
  assign rv4 = 1'b0;
  assign rd4 = '0;
`endif

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached n_assert=%0d n_fail=%0d", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic found;
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    rdy1   = 1'b1;
    rdy4   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u1_v", v1, 0);
    chk("rst_u1_addr", addr1, 0);
    chk("rst_u1_data", data1, 0);
    chk("rst_u1_done", done1, 0);
    chk("rst_u1_err", err1, 0);
    chk("rst_u4_v", v4, 0);
    chk("rst_u4_done", done4, 0);

    // Single core, ready tied high
`ifdef BP_CFG_LOADER_READBACK_EN
    corrupt1 = 1'b1;
`endif
    build_exp(1);
    @(negedge clk);
    rst1_n = 1'b1;
`ifdef BP_CFG_LOADER_READBACK_EN
    run_until_done(1, 400, 1'b0, "t5_done");
    chk("t5_err_npc", err1, 1);
`else
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) chk("t1_done_before_8", done1, 0);
    end
    chk("t1_done_at_8", done1, 1);
`endif
    cmp_list(1, "t1");
    repeat (5) begin
      @(posedge clk); #1;
      chk("t1_done_sticky", done1, 1);
      chk("t1_idle_v", v1, 0);
    end

    // Four cores, ready random 30%
    build_exp(4);
    got4.delete();
    @(negedge clk);
    rst4_n = 1'b1;
    rdy4   = 1'b0;
    run_until_done(4, 4000, 1'b1, "t2_done");
    rdy4 = 1'b1;
    cmp_list(4, "t2");
    chk("t2_err", err4, 0);

    // Long stall on the NPC write
    @(negedge clk);
    rst1_n = 1'b0;
    corrupt1 = 1'b0;
    @(negedge clk);
    got1.delete();
    build_exp(1);
    rdy1 = 1'b1;
    rst1_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      if (v1 && w1 && addr1 == 20'h00020) begin
        rdy1  = 1'b0;
        found = 1'b1;
      end
    end
    chk("t3_npc_presented", found, 1);
    repeat (50) begin
      @(posedge clk); #1;
      chk("t3_stall_v", v1, 1);
      chk("t3_stall_addr", addr1, 20'h00020);
      chk("t3_stall_data", data1, 64'h8000_0000);
    end
    rdy1 = 1'b1;
    run_until_done(1, 400, 1'b0, "t3_done");
    cmp_list(1, "t3");
    chk("t3_err", err1, 0);

    // Reset mid-sequence with core 1 ICACHE pending
    @(negedge clk);
    rst4_n = 1'b0;
    @(negedge clk);
    got4.delete();
    build_exp(4);
    rdy4 = 1'b1;
    rst4_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (v4 && w4 && addr4 == 20'h10030) begin
        rdy4  = 1'b0;
        found = 1'b1;
      end
    end
    chk("t4_icache1_presented", found, 1);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("t4_async_v", v4, 0);
    chk("t4_async_addr", addr4, 0);
    chk("t4_async_data", data4, 0);
    chk("t4_async_done", done4, 0);
    got4.delete();
    @(negedge clk);
    rst4_n = 1'b1;
    rdy4   = 1'b1;
    @(posedge clk); #1;
    chk("t4_restart_v", v4, 1);
    chk("t4_restart_addr", addr4, 20'h00010);
    run_until_done(4, 1000, 1'b0, "t4_done");
    cmp_list(4, "t4");

`ifdef BP_CFG_LOADER_READBACK_EN
    // Delayed readback responses
    @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    got1.delete();
    build_exp(1);
    dly1   = 10;
    rst1_n = 1'b1;
    run_until_done(1, 1000, 1'b0, "t6_done");
    cmp_list(1, "t6");
    chk("t6_err", err1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
